fdiv_ctrl: RTL and testbench

Programmable clock-divider controller that generates a divided clock-enable stream (`tick`) and a divided square wave (`clk_div`) from `clk_in`, for any integer ratio N in [2, 2^CNT_W−1]. Requesters change N through a valid/ready handshake. A new ratio and a start/stop request take effect only at a period boundary, so downstream logic never sees a truncated period. The block sits beside the fixed ÷2/÷3/÷4 divider and replaces hard-wired ratios wherever the ratio must be set at run time.

---
 rtl/fdiv_pkg.sv | 13 +
 rtl/fdiv_period_cnt.sv | 54 +++++
 rtl/fdiv_ctrl.sv | 108 ++++++++++
 tb/tb_fdiv_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fdiv_pkg.sv
// Shared types and constants for the programmable clock-divider controller.
package fdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } fdiv_state_t;

  localparam int FDIV_MIN_DIV = 2;
  localparam int FDIV_DEF_DIV = 2;

endpackage

// File: rtl/fdiv_period_cnt.sv
// Period counter: counts 0..div_cur-1 and registers tick/clk_div decoded
// from the next count and the next ratio.
module fdiv_period_cnt
  import fdiv_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load0,
  input  logic             run,
  input  logic [CNT_W-1:0] div_cur,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             clk_div,
  output logic             at_last
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             clk_div_q, clk_div_d;

  // div is the ratio in effect after this edge, so a ratio change is
  // reflected in tick/clk_div from the first cycle of the new period.
  always_comb begin
    at_last   = (cnt_q == div_cur - ONE);
    cnt_d     = cnt_q + ONE;
    if (!run || load0) begin
      cnt_d = '0;
    end
    tick_d    = run && (cnt_d == div - ONE);
    clk_div_d = run && (cnt_d < (div >> 1));
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      clk_div_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      clk_div_q <= clk_div_d;
    end
  end

  assign cnt     = cnt_q;
  assign tick    = tick_q;
  assign clk_div = clk_div_q;

endmodule

// File: rtl/fdiv_ctrl.sv
// Programmable clock-divider controller: run/stop FSM, ratio handshake and
// error reporting around the period counter.
module fdiv_ctrl
  import fdiv_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int DEF_DIV = FDIV_DEF_DIV
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_div,
  output logic             req_ready,
  output logic             err,
  output logic [CNT_W-1:0] div_cur,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             clk_div,
  output logic             busy
);

  fdiv_state_t      state_q, state_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] div_nxt_q, div_nxt_d;
  logic             err_q, err_d;
  logic             at_last, wrap, load0, accept, bad_req;

  assign req_ready = (state_q != PEND);
  assign busy      = (state_q != IDLE);
  assign accept    = req_valid && req_ready;
  assign bad_req   = (req_div < CNT_W'(FDIV_MIN_DIV));
  assign wrap      = at_last && (state_q != IDLE);
  assign load0     = wrap || (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    div_cur_d = div_cur_q;
    div_nxt_d = div_nxt_q;
    err_d     = 1'b0;
    if (accept && bad_req) begin
      err_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (accept && !bad_req) begin
          div_cur_d = req_div;
        end
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept && !bad_req) begin
          div_nxt_d = req_div;
          state_d   = PEND;
        end
        // A ratio accepted on the stopping wrap is applied directly.
        if (wrap && !en) begin
          state_d = IDLE;
          if (accept && !bad_req) begin
            div_cur_d = req_div;
          end
        end
      end
      PEND: begin
        if (wrap) begin
          div_cur_d = div_nxt_q;
          state_d   = en ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cur_q <= CNT_W'(DEF_DIV);
      div_nxt_q <= CNT_W'(DEF_DIV);
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cur_q <= div_cur_d;
      div_nxt_q <= div_nxt_d;
      err_q     <= err_d;
    end
  end

  fdiv_period_cnt #(
    .CNT_W(CNT_W)
  ) u_period_cnt (
    .clk_in (clk_in),
    .rst    (rst),
    .load0  (load0),
    .run    (state_d != IDLE),
    .div_cur(div_cur_q),
    .div    (div_cur_d),
    .cnt    (cnt),
    .tick   (tick),
    .clk_div(clk_div),
    .at_last(at_last)
  );

  assign div_cur = div_cur_q;
  assign err     = err_q;

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Directed self-checking bench for fdiv_ctrl with hand-computed expectations.
module tb_fdiv_ctrl;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic       req_valid;
  logic [3:0] req_div;
  logic       req_ready;
  logic       err;
  logic [3:0] div_cur;
  logic [3:0] cnt;
  logic       tick;
  logic       clk_div;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  fdiv_ctrl #(
    .CNT_W  (4),
    .DEF_DIV(2)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .req_valid(req_valid),
    .req_div  (req_div),
    .req_ready(req_ready),
    .err      (err),
    .div_cur  (div_cur),
    .cnt      (cnt),
    .tick     (tick),
    .clk_div  (clk_div),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
  task applyStimulus(input logic e, input logic v, input logic [3:0] d);
    en        = e;
    req_valid = v;
    req_div   = d;
    @(posedge clk_in);
    #1;
  endtask

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got {div,cnt,tick,clk,busy,rdy,err}=%h, expected %h",
               tag, obs, exp);
    end
  endtask

  task expectOutputs(input string tag, input int d, input int c, input int t,
                     input int ck, input int b, input int r, input int e);
    logic [31:0] obs, exp;
    obs = {19'd0, div_cur, cnt, tick, clk_div, busy, req_ready, err};
    exp = {19'd0, 4'(d), 4'(c), 1'(t), 1'(ck), 1'(b), 1'(r), 1'(e)};
    checkOutput(tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    expectOutputs("reset", 2, 0, 0, 0, 0, 1, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0);
      expectOutputs("idle", 2, 0, 0, 0, 0, 1, 0);
    end

    // N=2 run: tick and clk_div alternate every cycle
    applyStimulus(1, 0, 0);
    expectOutputs("n2_start", 2, 0, 0, 1, 1, 1, 0);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1, 0, 0);
      expectOutputs("n2_run", 2, i % 2, i % 2, (i % 2 == 0) ? 1 : 0, 1, 1, 0);
    end
    applyStimulus(0, 0, 0);
    expectOutputs("n2_stop", 2, 0, 0, 0, 0, 1, 0);

    // Ratio 3 loaded while idle, then 5 requested at cnt=0
    applyStimulus(0, 1, 3);
    expectOutputs("idle_load3", 3, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("n3_start", 3, 0, 0, 1, 1, 1, 0);
    applyStimulus(1, 1, 5);
    expectOutputs("pend5_c1", 3, 1, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("pend5_c2", 3, 2, 1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("n5_apply", 5, 0, 0, 1, 1, 1, 0);
    for (int c = 1; c < 5; c++) begin
      applyStimulus(1, 0, 0);
      expectOutputs("n5_run", 5, c, (c == 4) ? 1 : 0, (c < 2) ? 1 : 0, 1, 1, 0);
    end

    // Invalid ratio in RUN: err pulse only
    applyStimulus(1, 1, 1);
    expectOutputs("bad_req", 5, 0, 0, 1, 1, 1, 1);
    applyStimulus(1, 0, 0);
    expectOutputs("bad_after", 5, 1, 0, 1, 1, 1, 0);

    // Switch to N=4, then drop en at cnt=1
    applyStimulus(1, 1, 4);
    expectOutputs("pend4_c2", 5, 2, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("pend4_c3", 5, 3, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("pend4_c4", 5, 4, 1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("n4_apply", 4, 0, 0, 1, 1, 1, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("n4_c1", 4, 1, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0);
    expectOutputs("endrop_c2", 4, 2, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0);
    expectOutputs("endrop_c3", 4, 3, 1, 0, 1, 1, 0);
    applyStimulus(0, 0, 0);
    expectOutputs("endrop_idle", 4, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0);
    expectOutputs("endrop_idle2", 4, 0, 0, 0, 0, 1, 0);

    // Request on the start edge: first period already uses N=3
    applyStimulus(1, 1, 3);
    expectOutputs("start_req", 3, 0, 0, 1, 1, 1, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("start_c1", 3, 1, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("start_c2", 3, 2, 1, 0, 1, 1, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("start_wrap", 3, 0, 0, 1, 1, 1, 0);

    // Pending ratio and en drop on the same wrap: ratio applied, then IDLE
    applyStimulus(1, 1, 2);
    expectOutputs("pd_c1", 3, 1, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0);
    expectOutputs("pd_c2", 3, 2, 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0);
    expectOutputs("pd_idle", 2, 0, 0, 0, 0, 1, 0);

    // Reset while PEND at N=6 with 3 pending
    applyStimulus(0, 1, 6);
    expectOutputs("load6", 6, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("n6_start", 6, 0, 0, 1, 1, 1, 0);
    applyStimulus(1, 1, 3);
    expectOutputs("n6_pend", 6, 1, 0, 1, 1, 0, 0);
    rst = 1'b1;
    applyStimulus(1, 0, 0);
    expectOutputs("rst_pend", 2, 0, 0, 0, 0, 1, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0);
    expectOutputs("post_rst", 2, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("post_rst_s", 2, 0, 0, 1, 1, 1, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("post_rst_c1", 2, 1, 1, 0, 1, 1, 0);
    applyStimulus(1, 0, 0);
    expectOutputs("post_rst_w", 2, 0, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0);
    expectOutputs("final_c1", 2, 1, 1, 0, 1, 1, 0);
    applyStimulus(0, 0, 0);
    expectOutputs("final_idle", 2, 0, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
